// File: rtl/pack_receiver.sv
// pack_receiver: NoC ejection endpoint with address filtering, length policing and FWFT output FIFO.
module pack_receiver #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 4,
  parameter int ADDR         = 0,
  parameter int MEM_LOG2     = 4,
  parameter int MAX_PACK_LEN = 8
) (
  input  logic                           clk,
  input  logic                           a_rst,
  input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
  input  logic                           wr_ready_in,
  output logic                           r_ready_out,
  output logic [DATA_SIZE-1:0]           pkt_data_o,
  output logic                           pkt_last_o,
  output logic                           pkt_valid_o,
  input  logic                           pkt_ready_i,
  output logic [31:0]                    recv_packs,
  output logic [31:0]                    drop_packs,
  output logic                           err_addr,
  output logic                           err_len
);
  localparam int LW = $clog2(MAX_PACK_LEN + 1);
  localparam logic [ADDR_SIZE-1:0] ME = ADDR_SIZE'(ADDR);
  localparam logic [LW-1:0] MAXL = LW'(MAX_PACK_LEN);
  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;
  state_t state, nxt;
  logic rst_done;
  logic [LW-1:0] len;
  logic [DATA_SIZE:0] mem [2**MEM_LOG2];
  logic [MEM_LOG2-1:0] wp, rp;
  logic [MEM_LOG2:0] cnt;
  logic full, empty, acc, last, hit, over, push, pop;
  // cnt never exceeds the depth, so its MSB alone marks full
  assign full = cnt[MEM_LOG2];
  assign empty = cnt == '0;
  assign r_ready_out = rst_done && (state == DROP || !full);
  assign acc = wr_ready_in && r_ready_out;
  assign last = data_i[DATA_SIZE+ADDR_SIZE];
  assign hit = data_i[DATA_SIZE+:ADDR_SIZE] == ME;
  assign over = !last && (state == HEAD ? MAX_PACK_LEN == 1 : len + 1'b1 == MAXL);
  assign push = acc && (state == BODY || (state == HEAD && hit));
  assign pop = pkt_valid_o && pkt_ready_i;
  assign pkt_valid_o = !empty;
  assign {pkt_last_o, pkt_data_o} = empty ? '0 : mem[rp];
  // an overlength packet is closed early, then its remaining flits are dropped
  always_comb
    nxt = (state == DROP || (state == HEAD && !hit)) ? (last ? HEAD : DROP)
        : over ? DROP : last ? HEAD : BODY;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {last || over, data_i[DATA_SIZE-1:0]};
  always_ff @(posedge clk or posedge a_rst)
    if (a_rst) begin
      state      <= HEAD;
      rst_done   <= 1'b0;
      len        <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      recv_packs <= '0;
      drop_packs <= '0;
      err_addr   <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (acc) state <= nxt;
      if (push) len <= state == HEAD ? LW'(1) : len + 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (MEM_LOG2+1)'(push) - (MEM_LOG2+1)'(pop);
      if (push && (last || over)) recv_packs <= recv_packs + 32'd1;
      if (push && over) err_len <= 1'b1;
      if (acc && state == HEAD && !hit) begin
        drop_packs <= drop_packs + 32'd1;
        err_addr   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pack_receiver.sv
// tb_pack_receiver: directed checks of pack_receiver (ADDR=3, MAX_PACK_LEN=4, 4-entry FIFO).
module tb_pack_receiver;
  logic clk = 0, a_rst = 1, wr_ready_in = 0, pkt_ready_i = 0;
  logic [36:0] data_i = '0;
  logic r_ready_out, pkt_last_o, pkt_valid_o, err_addr, err_len;
  logic [31:0] pkt_data_o, recv_packs, drop_packs;
  int nchk = 0, nerr = 0, cyc = 0;
  logic [32:0] got[$];
  int stamp[$];

  pack_receiver #(.DATA_SIZE(32), .ADDR_SIZE(4), .ADDR(3), .MEM_LOG2(2), .MAX_PACK_LEN(4)) dut (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in), .r_ready_out(r_ready_out),
    .pkt_data_o(pkt_data_o), .pkt_last_o(pkt_last_o), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .recv_packs(recv_packs), .drop_packs(drop_packs), .err_addr(err_addr), .err_len(err_len));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!a_rst && pkt_valid_o && pkt_ready_i) begin
      got.push_back({pkt_last_o, pkt_data_o});
      stamp.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic l, input logic [3:0] d, input logic [31:0] p);
    int n = 0;
    data_i = {l, d, p};
    wr_ready_in = 1;
    @(negedge clk);
    while (!r_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!r_ready_out) chk("send_timeout", 64'(r_ready_out), 1);
    @(posedge clk);
    #1;
    wr_ready_in = 0;
  endtask

  task automatic chk_word(input string tag, input int i, input logic [32:0] exp);
    chk(tag, i < got.size() ? 64'(got[i]) : 64'hdead, 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    chk("rst_ready", 64'(r_ready_out), 0);
    chk("rst_valid", 64'(pkt_valid_o), 0);
    chk("rst_data", 64'({pkt_last_o, pkt_data_o}), 0);
    chk("rst_cnts", {recv_packs, drop_packs}, 0);
    chk("rst_errs", 64'({err_addr, err_len}), 0);
    a_rst = 0;
    chk("rel_ready_lo", 64'(r_ready_out), 0);
    idle(1);
    chk("rel_ready_hi", 64'(r_ready_out), 1);

    pkt_ready_i = 1;
    send(0, 3, 32'hA);
    send(0, 3, 32'hB);
    send(1, 3, 32'hC);
    idle(5);
    chk("t1_n", 64'(got.size()), 3);
    chk_word("t1_w0", 0, {1'b0, 32'hA});
    chk_word("t1_w1", 1, {1'b0, 32'hB});
    chk_word("t1_w2", 2, {1'b1, 32'hC});
    if (got.size() == 3) chk("t1_gap", 64'(stamp[2] - stamp[0]), 2);
    chk("t1_recv", 64'(recv_packs), 1);
    chk("t1_errs", 64'({err_addr, err_len, drop_packs}), 0);

    got.delete(); stamp.delete();
    send(0, 5, 32'h1);
    send(1, 5, 32'h2);
    send(1, 3, 32'h7);
    idle(5);
    chk("t2_n", 64'(got.size()), 1);
    chk_word("t2_w0", 0, {1'b1, 32'h7});
    chk("t2_drop", 64'(drop_packs), 1);
    chk("t2_eaddr", 64'(err_addr), 1);
    chk("t2_recv", 64'(recv_packs), 2);

    got.delete(); stamp.delete();
    for (int i = 0; i < 5; i++) send(0, 3, 32'h10 + 32'(i));
    send(1, 3, 32'h15);
    send(1, 3, 32'h20);
    idle(5);
    chk("t3_n", 64'(got.size()), 5);
    chk_word("t3_w0", 0, {1'b0, 32'h10});
    chk_word("t3_w2", 2, {1'b0, 32'h12});
    chk_word("t3_w3", 3, {1'b1, 32'h13});
    chk_word("t3_w4", 4, {1'b1, 32'h20});
    chk("t3_elen", 64'(err_len), 1);
    chk("t3_recv", 64'(recv_packs), 4);

    got.delete(); stamp.delete();
    pkt_ready_i = 0;
    for (int i = 0; i < 4; i++) send(1, 3, 32'h30 + 32'(i));
    data_i = {1'b1, 4'd3, 32'h34};
    wr_ready_in = 1;
    idle(2);
    chk("t4_full_rdy", 64'(r_ready_out), 0);
    chk("t4_full_recv", 64'(recv_packs), 8);
    chk("t4_head", 64'({pkt_valid_o, pkt_last_o, pkt_data_o}), {2'b11, 32'h30});
    pkt_ready_i = 1;
    chk("t4_pop_rdy_lo", 64'(r_ready_out), 0);
    idle(1);
    chk("t4_pop_rdy_hi", 64'(r_ready_out), 1);
    chk("t4_no_acc", 64'(recv_packs), 8);
    send(1, 3, 32'h34);
    send(1, 3, 32'h35);
    idle(8);
    chk("t4_n", 64'(got.size()), 6);
    for (int i = 0; i < 6; i++) chk_word($sformatf("t4_w%0d", i), i, {1'b1, 32'h30 + 32'(i)});
    chk("t4_recv", 64'(recv_packs), 10);

    got.delete(); stamp.delete();
    pkt_ready_i = 0;
    send(0, 3, 32'h40);
    send(0, 3, 32'h41);
    #1 a_rst = 1;
    #1;
    chk("t5_rst_valid", 64'({pkt_valid_o, pkt_last_o, pkt_data_o}), 0);
    chk("t5_rst_ready", 64'(r_ready_out), 0);
    chk("t5_rst_cnts", {recv_packs, drop_packs}, 0);
    chk("t5_rst_errs", 64'({err_addr, err_len}), 0);
    idle(2);
    a_rst = 0;
    pkt_ready_i = 1;
    send(1, 5, 32'h51);
    send(1, 3, 32'h50);
    idle(5);
    chk("t5_n", 64'(got.size()), 1);
    chk_word("t5_w0", 0, {1'b1, 32'h50});
    chk("t5_recv", 64'(recv_packs), 1);
    chk("t5_drop", 64'(drop_packs), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
